// File: rtl/lif_array_scheduler.sv
// Time-multiplexed leaky integrate-and-fire engine: one shared update datapath
// sweeps NUM_NEURONS register-held neurons per step and queues spike IDs in a FIFO.
module lif_array_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3,
  parameter int LEAK_SHIFT  = 1,
  parameter int REFRACT     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [7:0]       threshold,
  input  logic             cur_we,
  input  logic [IDX_W-1:0] cur_addr,
  input  logic [7:0]       cur_data,
  input  logic [IDX_W-1:0] mon_idx,
  output logic [7:0]       mon_state,
  output logic             spk_valid,
  output logic [IDX_W-1:0] spk_id,
  input  logic             spk_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_STALL, S_DONE} fsm_e;

  fsm_e             fsm, fsm_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             pending, pending_nx;
  logic             overrun_r, overrun_nx;

  logic [7:0] mem    [NUM_NEURONS];
  logic [7:0] cur_r  [NUM_NEURONS];
  logic [7:0] refr   [NUM_NEURONS];

  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic       full, do_upd, in_refr, fire, push, pop;
  logic [7:0] leaked, sum8;
  logic [8:0] sum9;

  // Stall is decided from the registered count only, so a full FIFO never
  // sees a push and ready has no combinational path into the sweep.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_upd  = (fsm == S_SWEEP) && !full;
  assign in_refr = (refr[idx] != 8'd0);
  assign leaked  = mem[idx] - (mem[idx] >> LEAK_SHIFT);
  assign sum9    = {1'b0, leaked} + {1'b0, cur_r[idx]};
  assign sum8    = sum9[8] ? 8'hff : sum9[7:0];
  assign fire    = do_upd && !in_refr && (sum8 >= threshold);
  assign push    = fire;
  assign pop     = spk_valid && spk_ready;

  assign spk_valid = (count != '0);
  assign spk_id    = spk_valid ? fifo_q[rd_ptr] : '0;
  assign mon_state = mem[mon_idx];
  assign busy      = (fsm == S_SWEEP) || (fsm == S_STALL);
  assign overrun   = overrun_r;

  always_comb begin
    fsm_nx     = fsm;
    idx_nx     = idx;
    pending_nx = pending;
    overrun_nx = overrun_r;
    done       = 1'b0;
    case (fsm)
      S_IDLE: begin
        if (step) begin
          fsm_nx = S_SWEEP;
          idx_nx = '0;
        end
      end
      S_SWEEP, S_STALL: begin
        if (step) begin
          if (pending) overrun_nx = 1'b1;
          else         pending_nx = 1'b1;
        end
        if (fsm == S_STALL) begin
          if (!full) fsm_nx = S_SWEEP;
        end else if (full) begin
          fsm_nx = S_STALL;
        end else if (idx == IDX_W'(NUM_NEURONS - 1)) begin
          fsm_nx = S_DONE;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        done       = 1'b1;
        pending_nx = 1'b0;
        // A step landing in DONE counts as the pending request for the next sweep.
        if (step && pending) overrun_nx = 1'b1;
        if (step || pending) begin
          fsm_nx = S_SWEEP;
          idx_nx = '0;
        end else begin
          fsm_nx = S_IDLE;
        end
      end
      default: fsm_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      fsm       <= fsm_nx;
      idx       <= idx_nx;
      pending   <= pending_nx;
      overrun_r <= overrun_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i]   <= '0;
        cur_r[i] <= '0;
        refr[i]  <= '0;
      end
    end else begin
      if (cur_we) cur_r[cur_addr] <= cur_data;
      if (do_upd) begin
        if (in_refr) begin
          mem[idx]  <= '0;
          refr[idx] <= refr[idx] - 8'd1;
        end else if (fire) begin
          mem[idx]  <= '0;
          refr[idx] <= 8'(REFRACT);
        end else begin
          mem[idx]  <= sum8;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= idx;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_array_scheduler.sv
// Directed bench for lif_array_scheduler: spike IDs checked by a scoreboard
// monitor; timing, state and flag checks made inline by the stimulus.
module tb_lif_array_scheduler;
  logic       clk = 1'b0;
  logic       rst, step, cur_we, spk_ready;
  logic [7:0] threshold, cur_data, mon_state;
  logic [2:0] cur_addr, mon_idx, spk_id;
  logic       spk_valid, busy, done, overrun;

  int n_pass  = 0;
  int n_total = 0;
  int sb[$];

  lif_array_scheduler #(.NUM_NEURONS(8), .IDX_W(3), .LEAK_SHIFT(1), .REFRACT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .step(step), .threshold(threshold),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .mon_idx(mon_idx), .mon_state(mon_state),
    .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted spike must match the queue head.
  always @(negedge clk) begin
    if (!rst && spk_valid && spk_ready) begin
      if (sb.size() == 0) check("spk_unexpected", int'(spk_id), -1);
      else                check("spk_id", int'(spk_id), sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step = 1'b1;
    tick(); tick();
    rst = 1'b0; step = 1'b0;
  endtask

  task automatic write_cur(input int a, input int d);
    cur_we = 1'b1; cur_addr = 3'(a); cur_data = 8'(d);
    tick();
    cur_we = 1'b0;
  endtask

  // lat = cycles from the step cycle to the done cycle; bcnt = busy cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    int n;
    n = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
      if (done) break;
      if (n > 200) begin
        check("done_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      step = 1'b0;
    end
    lat = n - 1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic do_step(output int lat, output int bcnt);
    step = 1'b1;
    wait_done(lat, bcnt);
  endtask

  initial begin
    int lat, bc;
    int exp_s0[6];
    exp_s0 = '{120, 180, 0, 0, 0, 120};
    rst = 1'b1; step = 1'b0; threshold = 8'd0; cur_we = 1'b0;
    cur_addr = '0; cur_data = '0; mon_idx = '0; spk_ready = 1'b0;
    tick();

    // Reset with step asserted throughout: nothing may start.
    do_reset();
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_spk_valid", spk_valid, 0);
    check("rst_spk_id", spk_id, 0);
    for (int i = 0; i < 8; i++) begin
      mon_idx = 3'(i); #1;
      check("rst_mon_state", mon_state, 0);
    end
    tick();

    // Single neuron integrate / fire / refractory sequence.
    threshold = 8'd200; spk_ready = 1'b1; mon_idx = 3'd0;
    write_cur(0, 120);
    for (int s = 0; s < 6; s++) begin
      if (s == 2) sb.push_back(0);
      do_step(lat, bc);
      check("seq_busy_cycles", bc, 8);
      check("seq_done_latency", lat, 9);
      check("seq_state_n0", mon_state, exp_s0[s]);
    end
    check("seq_sb_empty", sb.size(), 0);

    // Backpressure: FIFO fills, sweep stalls at idx 4 until drained.
    do_reset();
    threshold = 8'd255; spk_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_cur(i, 255);
    for (int i = 0; i < 8; i++) sb.push_back(i);
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("stall_busy", busy, 1);
    check("stall_done", done, 0);
    check("stall_spk_valid", spk_valid, 1);
    check("stall_sb_left", sb.size(), 8);
    tick();
    spk_ready = 1'b1;
    wait_done(lat, bc);
    tick();
    check("stall_sb_empty", sb.size(), 0);
    check("stall_idle", busy, 0);

    // Pending step chains a second sweep; a third step sets sticky overrun.
    do_reset();
    threshold = 8'd255;
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    step = 1'b1; tick(); step = 1'b0;
    wait_done(lat, bc);
    @(negedge clk);
    check("pend_busy_again", busy, 1);
    check("pend_overrun0", overrun, 0);
    tick();
    wait_done(lat, bc);
    check("pend_overrun0b", overrun, 0);
    @(negedge clk);
    check("pend_idle", busy, 0);
    tick();
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0;
    @(negedge clk);
    check("ovr_set", overrun, 1);
    tick();
    wait_done(lat, bc);
    wait_done(lat, bc);
    tick(); tick();
    @(negedge clk);
    check("ovr_sticky", overrun, 1);
    check("ovr_idle", busy, 0);
    tick();
    do_reset();
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    tick();

    // Current write colliding with the update of the same neuron.
    threshold = 8'd255; mon_idx = 3'd2;
    write_cur(2, 10);
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    cur_we = 1'b1; cur_addr = 3'd2; cur_data = 8'd50;
    tick();
    cur_we = 1'b0;
    wait_done(lat, bc);
    check("wr_old_cur", mon_state, 10);
    do_step(lat, bc);
    check("wr_new_cur", mon_state, 55);

    // threshold 0: all neurons spike on steps 1, 4, 7 only.
    do_reset();
    threshold = 8'd0; spk_ready = 1'b1; mon_idx = 3'd5;
    for (int s = 1; s <= 7; s++) begin
      if (s == 1 || s == 4 || s == 7)
        for (int i = 0; i < 8; i++) sb.push_back(i);
      do_step(lat, bc);
      tick();
      check("thr0_sb_empty", sb.size(), 0);
      check("thr0_state", mon_state, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
